// File: rtl/match_pulse_gen.sv
// Multi-channel value-match detector: one WAIT/HIT/HOLD FSM per target with PULSE, EDGE or STICKY hit modes.
// Define MATCH_COUNT_EN to add saturating per-channel hit counters (hit_count output, clr_cnt input).
module match_pulse_gen #(
    parameter int unsigned WIDTH     = 20,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          enable,
    input  logic [WIDTH-1:0]              value,
    input  logic [CHANNELS*WIDTH-1:0]     target,
    input  logic [2*CHANNELS-1:0]         mode,
    input  logic [CHANNELS-1:0]           ack,
`ifdef MATCH_COUNT_EN
    input  logic                          clr_cnt,
    output logic [CNT_WIDTH*CHANNELS-1:0] hit_count,
`endif
    output logic [CHANNELS-1:0]           hit,
    output logic                          hit_any
);

    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_HIT  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [1:0] MODE_PULSE  = 2'd0;
    localparam logic [1:0] MODE_EDGE   = 2'd1;
    localparam logic [1:0] MODE_STICKY = 2'd2;

    if (WIDTH == 0 || CHANNELS == 0 || CNT_WIDTH == 0) begin : g_param_check
        $error("match_pulse_gen: WIDTH, CHANNELS and CNT_WIDTH must be non-zero");
    end

    logic [CHANNELS-1:0][1:0] state_q;
    logic [CHANNELS-1:0][1:0] state_d;
    logic [CHANNELS-1:0]      eq;

    // Mode 3 and PULSE share the default HIT branch, so both drop back to WAIT.
    function automatic logic [1:0] next_state(
        input logic [1:0] cur,
        input logic [1:0] md,
        input logic       match,
        input logic       clr,
        input logic       en
    );
        logic [1:0] nxt;
        nxt = ST_WAIT;
        if (en) begin
            case (cur)
                ST_WAIT: nxt = match ? ST_HIT : ST_WAIT;
                ST_HIT: begin
                    case (md)
                        MODE_EDGE:   nxt = match ? ST_HOLD : ST_WAIT;
                        MODE_STICKY: nxt = clr ? ST_WAIT : ST_HIT;
                        MODE_PULSE:  nxt = ST_WAIT;
                        default:     nxt = ST_WAIT;
                    endcase
                end
                ST_HOLD: nxt = (md == MODE_EDGE && match) ? ST_HOLD : ST_WAIT;
                default: nxt = ST_WAIT;
            endcase
        end
        return nxt;
    endfunction

    always_comb begin
        eq = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            eq[i] = (value == target[i*WIDTH +: WIDTH]);
        end
    end

    always_comb begin
        state_d = state_q;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            state_d[i] = next_state(state_q[i], mode[2*i +: 2], eq[i], ack[i], enable);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            hit[i] = (state_q[i] == ST_HIT);
        end
    end

    assign hit_any = |hit;

`ifdef MATCH_COUNT_EN
    logic [CHANNELS-1:0][CNT_WIDTH-1:0] cnt_q;
    logic [CHANNELS-1:0][CNT_WIDTH-1:0] cnt_d;

    // Counts WAIT->HIT entries only; clr_cnt wins over a coincident increment.
    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (clr_cnt) begin
                cnt_d[i] = '0;
            end else if (state_q[i] == ST_WAIT && state_d[i] == ST_HIT && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_count = cnt_q;
`endif

endmodule
